// File: rtl/chord_voice_allocator_if.sv
// Load/commit handshake and per-voice output bus of the chord voice allocator.
// The master drives notes and timing strobes; the slave is the allocator.
interface chord_voice_allocator_if #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
);
  localparam int CNT_W = $clog2(NUM_VOICES + 1);

  logic                         beat;
  logic                         play;
  logic                         load_valid;
  logic                         load_ready;
  logic                         chord_load;
  logic [NOTE_W-1:0]            note_in;
  logic [DUR_W-1:0]             duration_in;
  logic                         commit;
  logic [NUM_VOICES*NOTE_W-1:0] voice_note;
  logic [NUM_VOICES*DUR_W-1:0]  voice_remaining;
  logic [NUM_VOICES-1:0]        voice_active;
  logic [NUM_VOICES-1:0]        voice_new;
  logic [CNT_W-1:0]             staged_count;
  logic                         dropped;
  logic                         all_idle;

  modport master (
    output beat, play, load_valid, chord_load, note_in, duration_in, commit,
    input  load_ready, voice_note, voice_remaining, voice_active, voice_new,
           staged_count, dropped, all_idle
  );

  modport slave (
    input  beat, play, load_valid, chord_load, note_in, duration_in, commit,
    output load_ready, voice_note, voice_remaining, voice_active, voice_new,
           staged_count, dropped, all_idle
  );
endinterface

// File: rtl/chord_voice_allocator.sv
// NUM_VOICES note/duration slots counted down on the beat. Notes arrive as an
// atomically committed staged chord or as single notes allocated to a free voice.
module chord_voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter bit STEAL_EN   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  chord_voice_allocator_if.slave bus
);
  localparam int               CNT_W = $clog2(NUM_VOICES + 1);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(NUM_VOICES);

  typedef enum logic {V_IDLE, V_ACTIVE}        voice_state_e;
  typedef enum logic {TOP_EMPTY, TOP_STAGING}  top_state_e;

  // Voice slots and the chord staging buffer
  voice_state_e          voice_state_q [NUM_VOICES];
  logic [NOTE_W-1:0]     note_q        [NUM_VOICES];
  logic [DUR_W-1:0]      rem_q         [NUM_VOICES];
  logic [NOTE_W-1:0]     stage_note_q  [NUM_VOICES];
  logic [DUR_W-1:0]      stage_dur_q   [NUM_VOICES];
  logic [CNT_W-1:0]      staged_cnt_q;
  top_state_e            top_state_q;
  logic [NUM_VOICES-1:0] voice_new_q;
  logic                  dropped_q;
  logic                  all_idle_q;
  logic                  ready_q;

  logic                  accept;
  logic                  single_acc;
  logic                  chord_acc;
  logic                  chord_full;
  logic                  tick;
  logic                  free_found;
  logic                  single_drop;
  logic [DUR_W-1:0]      best_rem;
  logic [CNT_W-1:0]      staged_cnt_next;
  logic [NUM_VOICES-1:0] active_mask;
  logic [NUM_VOICES-1:0] free_mask;
  logic [NUM_VOICES-1:0] steal_mask;
  logic [NUM_VOICES-1:0] wr_mask;
  logic [NUM_VOICES-1:0] expire_mask;
  logic [NUM_VOICES-1:0] commit_mask;
  logic [NUM_VOICES-1:0] active_next;

  // A load offered during commit is simply not accepted, so it never drops.
  assign bus.load_ready = ready_q & ~bus.commit;
  assign accept         = bus.load_valid & bus.load_ready;
  assign single_acc     = accept & ~bus.chord_load & (bus.duration_in != '0);
  assign chord_acc      = accept & bus.chord_load;
  assign chord_full     = (staged_cnt_q == DEPTH);
  assign tick           = bus.beat & bus.play;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    active_mask   = '0;
    free_mask     = '0;
    free_found    = 1'b0;
    commit_mask   = '0;
    steal_mask    = '0;
    steal_mask[0] = 1'b1;
    best_rem      = rem_q[0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      active_mask[i] = (voice_state_q[i] == V_ACTIVE);
      if (!free_found && voice_state_q[i] == V_IDLE) begin
        free_mask[i] = 1'b1;
        free_found   = 1'b1;
      end
      commit_mask[i] = (CNT_W'(i) < staged_cnt_q) && (stage_dur_q[i] != '0);
    end
    // Steal victim: smallest remaining count, strict compare keeps the lowest index on ties
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (rem_q[i] < best_rem) begin
        best_rem      = rem_q[i];
        steal_mask    = '0;
        steal_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    wr_mask     = '0;
    single_drop = 1'b0;
    if (single_acc) begin
      if (free_found)    wr_mask = free_mask;
      else if (STEAL_EN) wr_mask = steal_mask;
      else               single_drop = 1'b1;
    end
    expire_mask = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      expire_mask[i] = tick & active_mask[i] & ~wr_mask[i] & (rem_q[i] == DUR_W'(1));
    end
    if (bus.commit) begin
      active_next     = commit_mask;
      staged_cnt_next = '0;
    end else begin
      active_next     = (active_mask & ~expire_mask) | wr_mask;
      staged_cnt_next = (chord_acc && !chord_full) ? staged_cnt_q + CNT_W'(1) : staged_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the voice and staging arrays are small register files read directly by the players, so they are reset like any other state.
      for (int k = 0; k < NUM_VOICES; k++) begin
        voice_state_q[k] <= V_IDLE;
        note_q[k]        <= '0;
        rem_q[k]         <= '0;
        stage_note_q[k]  <= '0;
        stage_dur_q[k]   <= '0;
      end
      staged_cnt_q <= '0;
      top_state_q  <= TOP_EMPTY;
      voice_new_q  <= '0;
      dropped_q    <= 1'b0;
      all_idle_q   <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ready_q      <= 1'b1;
      voice_new_q  <= '0;
      dropped_q    <= single_drop | (chord_acc & chord_full);
      all_idle_q   <= ~|active_next && (staged_cnt_next == '0);
      staged_cnt_q <= staged_cnt_next;

      if (bus.commit) begin
        // Every voice is rewritten by a commit, so a simultaneous beat decrements nothing
        for (int k = 0; k < NUM_VOICES; k++) begin
          if (CNT_W'(k) < staged_cnt_q) begin
            note_q[k] <= stage_note_q[k];
            rem_q[k]  <= stage_dur_q[k];
          end else begin
            rem_q[k]  <= '0;
          end
          voice_state_q[k] <= commit_mask[k] ? V_ACTIVE : V_IDLE;
          voice_new_q[k]   <= commit_mask[k];
          stage_note_q[k]  <= '0;
          stage_dur_q[k]   <= '0;
        end
      end else begin
        for (int k = 0; k < NUM_VOICES; k++) begin
          if (wr_mask[k]) begin
            note_q[k]        <= bus.note_in;
            rem_q[k]         <= bus.duration_in;
            voice_state_q[k] <= V_ACTIVE;
            voice_new_q[k]   <= 1'b1;
          end else if (tick && active_mask[k]) begin
            rem_q[k] <= (rem_q[k] == '0) ? '0 : rem_q[k] - DUR_W'(1);
            if (expire_mask[k]) voice_state_q[k] <= V_IDLE;
          end
          if (chord_acc && !chord_full && CNT_W'(k) == staged_cnt_q) begin
            stage_note_q[k] <= bus.note_in;
            stage_dur_q[k]  <= bus.duration_in;
          end
        end
      end

      case (top_state_q)
        TOP_EMPTY:   if (chord_acc && !chord_full) top_state_q <= TOP_STAGING;
        TOP_STAGING: if (bus.commit)               top_state_q <= TOP_EMPTY;
        default:                                   top_state_q <= TOP_EMPTY;
      endcase
    end
  end

  always_comb begin
    bus.voice_note      = '0;
    bus.voice_remaining = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      bus.voice_note[i*NOTE_W +: NOTE_W]     = note_q[i];
      bus.voice_remaining[i*DUR_W +: DUR_W]  = rem_q[i];
    end
  end

  assign bus.voice_active = active_mask;
  assign bus.voice_new    = voice_new_q;
  assign bus.staged_count = staged_cnt_q;
  assign bus.dropped      = dropped_q;
  assign bus.all_idle     = all_idle_q;
endmodule

// File: tb/tb_chord_voice_allocator.sv
// Scoreboard bench: one stealing and one dropping allocator driven in lockstep;
// expectations are queued with each stimulus and compared after the clock edge.
module tb_chord_voice_allocator;
  localparam int NV = 3;
  localparam int NW = 6;
  localparam int DW = 7;

  typedef enum int {O_ACTIVE, O_NEW, O_NOTE, O_REM, O_STAGED, O_DROPPED, O_IDLE, O_READY} obs_e;
  typedef struct {
    string tag;
    int    dut;
    obs_e  obs;
    int    voice;
    int    exp;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  chord_voice_allocator_if #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) bus_s ();
  chord_voice_allocator_if #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) bus_d ();

  chord_voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .STEAL_EN(1'b1)) dut_s (
    .clk(clk), .reset(reset), .bus(bus_s)
  );
  chord_voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .STEAL_EN(1'b0)) dut_d (
    .clk(clk), .reset(reset), .bus(bus_d)
  );

  assign bus_d.beat        = bus_s.beat;
  assign bus_d.play        = bus_s.play;
  assign bus_d.load_valid  = bus_s.load_valid;
  assign bus_d.chord_load  = bus_s.chord_load;
  assign bus_d.note_in     = bus_s.note_in;
  assign bus_d.duration_in = bus_s.duration_in;
  assign bus_d.commit      = bus_s.commit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int dut, input obs_e obs, input int v);
    logic [31:0] r;
    r = '0;
    case (obs)
      O_ACTIVE:  r = (dut == 0) ? 32'(bus_s.voice_active) : 32'(bus_d.voice_active);
      O_NEW:     r = (dut == 0) ? 32'(bus_s.voice_new)    : 32'(bus_d.voice_new);
      O_NOTE:    r = (dut == 0) ? 32'(bus_s.voice_note[v*NW +: NW]) : 32'(bus_d.voice_note[v*NW +: NW]);
      O_REM:     r = (dut == 0) ? 32'(bus_s.voice_remaining[v*DW +: DW]) : 32'(bus_d.voice_remaining[v*DW +: DW]);
      O_STAGED:  r = (dut == 0) ? 32'(bus_s.staged_count) : 32'(bus_d.staged_count);
      O_DROPPED: r = (dut == 0) ? 32'(bus_s.dropped)      : 32'(bus_d.dropped);
      O_IDLE:    r = (dut == 0) ? 32'(bus_s.all_idle)     : 32'(bus_d.all_idle);
      O_READY:   r = (dut == 0) ? 32'(bus_s.load_ready)   : 32'(bus_d.load_ready);
      default:   r = '0;
    endcase
    return r;
  endfunction

  task automatic push(input string tag, input int dut, input obs_e obs, input int v, input int exp);
    exp_t e;
    e.tag = tag; e.dut = dut; e.obs = obs; e.voice = v; e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic pushb(input string tag, input obs_e obs, input int v, input int exp);
    push(tag, 0, obs, v, exp);
    push(tag, 1, obs, v, exp);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s[dut%0d]", e.tag, e.dut), observe(e.dut, e.obs, e.voice), e.exp);
    end
  endtask

  // One clock: inputs set beforehand are sampled, one-shot strobes are cleared, then the scoreboard drains
  task automatic step();
    @(posedge clk);
    #1;
    bus_s.load_valid = 1'b0;
    bus_s.commit     = 1'b0;
    bus_s.beat       = 1'b0;
    drain();
  endtask

  task automatic stage(input int n, input int d);
    bus_s.load_valid  = 1'b1;
    bus_s.chord_load  = 1'b1;
    bus_s.note_in     = NW'(n);
    bus_s.duration_in = DW'(d);
  endtask

  task automatic single(input int n, input int d);
    bus_s.load_valid  = 1'b1;
    bus_s.chord_load  = 1'b0;
    bus_s.note_in     = NW'(n);
    bus_s.duration_in = DW'(d);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_s.play = 1'b0;
    pushb("ready_after_rst", O_READY, 0, 1);
    step();
  endtask

  task automatic chord_basic();
    stage(23, 10); pushb("stg1", O_STAGED, 0, 1); pushb("idle_stg", O_IDLE, 0, 0); step();
    stage(11, 10); pushb("stg2", O_STAGED, 0, 2); step();
    stage(7, 12);  pushb("stg3", O_STAGED, 0, 3); pushb("act_pre", O_ACTIVE, 0, 0); step();
    bus_s.commit = 1'b1;
    #1;
    pushb("ready_commit", O_READY, 0, 0); drain();
    pushb("new_commit", O_NEW, 0, 7); pushb("act_commit", O_ACTIVE, 0, 7);
    pushb("note0", O_NOTE, 0, 23); pushb("note1", O_NOTE, 1, 11); pushb("note2", O_NOTE, 2, 7);
    pushb("rem0", O_REM, 0, 10); pushb("rem2", O_REM, 2, 12); pushb("stg_clr", O_STAGED, 0, 0);
    step();
    pushb("new_clr", O_NEW, 0, 0); step();
    bus_s.play = 1'b1;
    repeat (9) begin bus_s.beat = 1'b1; step(); end
    bus_s.beat = 1'b1;
    pushb("act_10b", O_ACTIVE, 0, 4); pushb("rem2_10b", O_REM, 2, 2); pushb("rem0_10b", O_REM, 0, 0);
    step();
    bus_s.beat = 1'b1; step();
    bus_s.beat = 1'b1;
    pushb("act_12b", O_ACTIVE, 0, 0); pushb("idle_12b", O_IDLE, 0, 1);
    step();
    bus_s.play = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus_s.beat = 1'b0; bus_s.play = 1'b0; bus_s.load_valid = 1'b0; bus_s.chord_load = 1'b0;
    bus_s.note_in = '0; bus_s.duration_in = '0; bus_s.commit = 1'b0;
    #2;
    pushb("rst_ready", O_READY, 0, 0); pushb("rst_idle", O_IDLE, 0, 1); pushb("rst_active", O_ACTIVE, 0, 0);
    pushb("rst_staged", O_STAGED, 0, 0); pushb("rst_new", O_NEW, 0, 0); pushb("rst_drop", O_DROPPED, 0, 0);
    pushb("rst_rem1", O_REM, 1, 0);
    drain();
    @(posedge clk);
    #1;
    reset = 1'b0;
    pushb("ready_first", O_READY, 0, 1);
    step();

    // Chord load and commit
    chord_basic();

    // Single-note fill and frozen countdown
    apply_reset();
    single(50, 20); pushb("s_new0", O_NEW, 0, 1); pushb("s_note0", O_NOTE, 0, 50); pushb("s_rem0", O_REM, 0, 20); step();
    single(51, 15); pushb("s_new1", O_NEW, 0, 2); pushb("s_act2", O_ACTIVE, 0, 3); step();
    single(10, 80); pushb("s_new2", O_NEW, 0, 4); pushb("s_note2", O_NOTE, 2, 10);
    pushb("s_rem2", O_REM, 2, 80); pushb("s_act3", O_ACTIVE, 0, 7); step();
    repeat (4) begin bus_s.beat = 1'b1; step(); end
    bus_s.beat = 1'b1; pushb("frz_rem2", O_REM, 2, 80); pushb("frz_rem0", O_REM, 0, 20); step();
    bus_s.play = 1'b1; bus_s.beat = 1'b1;
    pushb("run_rem2", O_REM, 2, 79); pushb("run_rem1", O_REM, 1, 14); step();
    bus_s.play = 1'b0;
    single(9, 0); pushb("z_new", O_NEW, 0, 0); pushb("z_drop", O_DROPPED, 0, 0);
    pushb("z_act", O_ACTIVE, 0, 7); pushb("z_note0", O_NOTE, 0, 50); step();

    // Steal versus drop
    apply_reset();
    single(1, 20); step();
    single(2, 3);  step();
    single(3, 3);  pushb("st_act", O_ACTIVE, 0, 7); step();
    single(11, 85);
    push("st_new", 0, O_NEW, 0, 2); push("st_note1", 0, O_NOTE, 1, 11);
    push("st_rem1", 0, O_REM, 1, 85); push("st_drop", 0, O_DROPPED, 0, 0); push("st_rem0", 0, O_REM, 0, 20);
    push("dr_new", 1, O_NEW, 0, 0); push("dr_note1", 1, O_NOTE, 1, 2); push("dr_rem1", 1, O_REM, 1, 3);
    push("dr_drop", 1, O_DROPPED, 0, 1); push("dr_act", 1, O_ACTIVE, 0, 7);
    step();
    push("dr_drop_once", 1, O_DROPPED, 0, 0); step();

    // Staging overflow and commit priority
    apply_reset();
    stage(5, 4); step();
    stage(6, 4); step();
    stage(7, 4); pushb("ov_drop3", O_DROPPED, 0, 0); pushb("ov_stg3", O_STAGED, 0, 3); step();
    stage(8, 4); pushb("ov_drop4", O_DROPPED, 0, 1); pushb("ov_stg4", O_STAGED, 0, 3); step();
    stage(9, 9); bus_s.commit = 1'b1;
    #1;
    pushb("cp_ready", O_READY, 0, 0); drain();
    pushb("cp_stg", O_STAGED, 0, 0); pushb("cp_drop", O_DROPPED, 0, 0); pushb("cp_new", O_NEW, 0, 7);
    pushb("cp_note0", O_NOTE, 0, 5); pushb("cp_note2", O_NOTE, 2, 7); pushb("cp_rem0", O_REM, 0, 4);
    step();
    pushb("cp_stg_after", O_STAGED, 0, 0); pushb("cp_idle", O_IDLE, 0, 0); step();

    // Simultaneous expiry, allocation and commit
    apply_reset();
    bus_s.play = 1'b1;
    single(1, 1); step();
    single(2, 5); step();
    bus_s.beat = 1'b1; single(3, 9);
    pushb("sim_new", O_NEW, 0, 4); pushb("sim_note2", O_NOTE, 2, 3); pushb("sim_rem2", O_REM, 2, 9);
    pushb("sim_act", O_ACTIVE, 0, 6); pushb("sim_rem1", O_REM, 1, 4); pushb("sim_rem0", O_REM, 0, 0);
    step();
    single(4, 1); pushb("sim2_new", O_NEW, 0, 1); pushb("sim2_act", O_ACTIVE, 0, 7); step();
    bus_s.beat = 1'b1; single(5, 6);
    push("sx_new", 0, O_NEW, 0, 1); push("sx_note0", 0, O_NOTE, 0, 5); push("sx_rem0", 0, O_REM, 0, 6);
    push("sx_act", 0, O_ACTIVE, 0, 7); push("sx_rem1", 0, O_REM, 1, 3); push("sx_rem2", 0, O_REM, 2, 8);
    push("dx_new", 1, O_NEW, 0, 0); push("dx_act", 1, O_ACTIVE, 0, 6); push("dx_drop", 1, O_DROPPED, 0, 1);
    push("dx_rem1", 1, O_REM, 1, 3);
    step();
    stage(20, 5); step();
    stage(21, 0); pushb("cb_stg", O_STAGED, 0, 2); step();
    bus_s.commit = 1'b1; bus_s.beat = 1'b1;
    pushb("cb_new", O_NEW, 0, 1); pushb("cb_act", O_ACTIVE, 0, 1); pushb("cb_rem0", O_REM, 0, 5);
    pushb("cb_note0", O_NOTE, 0, 20); pushb("cb_note1", O_NOTE, 1, 21); pushb("cb_rem1", O_REM, 1, 0);
    pushb("cb_rem2", O_REM, 2, 0); pushb("cb_stg0", O_STAGED, 0, 0);
    step();
    bus_s.play = 1'b0;

    // Asynchronous reset with two voices active and one note staged
    single(30, 7); pushb("mr_new", O_NEW, 0, 2); pushb("mr_act", O_ACTIVE, 0, 3); step();
    stage(40, 3); pushb("mr_stg", O_STAGED, 0, 1); step();
    #3;
    reset = 1'b1;
    #1;
    pushb("ar_act", O_ACTIVE, 0, 0); pushb("ar_stg", O_STAGED, 0, 0); pushb("ar_ready", O_READY, 0, 0);
    pushb("ar_idle", O_IDLE, 0, 1); pushb("ar_rem0", O_REM, 0, 0);
    drain();
    @(posedge clk);
    #1;
    reset = 1'b0;
    pushb("ar_ready_rel", O_READY, 0, 1);
    step();
    chord_basic();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
